exe_stage: RTL

- Execute stage of the 5-stage processor. Sits directly downstream of the decode/execute pipeline register (depipe) and consumes its *_E outputs.
- Contains the ALU, the NZCV flag register, branch resolution, and an iterative 32-cycle multiplier that stalls upstream.
- Ends in the execute/memory pipeline register that drives the *_M signals into the memory stage.

---
 rtl/exe_pkg.sv | 34 +++
 rtl/exe_stage_seq_mul.sv | 59 +++++
 rtl/exe_stage.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/exe_pkg.sv
// Shared types and constants for the execute stage: ALU op codes, NZCV flags,
// E/M bubble values and the multiplier FSM states.
package exe_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_AND = 4'b0010,
        OP_OR  = 4'b0011,
        OP_XOR = 4'b0100,
        OP_SHL = 4'b0101,
        OP_SHR = 4'b0110,
        OP_CMP = 4'b0111,
        OP_MUL = 4'b1000,
        OP_MOV = 4'b1001
    } alu_op_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    localparam logic        BUBBLE_CTL  = 1'b0;
    localparam logic [3:0]  BUBBLE_SCR  = 4'b0000;
    localparam logic [31:0] BUBBLE_DATA = 32'h0000_0000;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mul_state_t;

endpackage

// File: rtl/exe_stage_seq_mul.sv
// Iterative shift-add multiplier (low WIDTH bits of a*b, unsigned), one step per clock.
// Only instantiated by exe_stage when EXE_MUL_EN is defined.
module seq_mul
    import exe_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             last,
    output logic [WIDTH-1:0] result
);
    localparam int CNT_W = $clog2(MUL_CYCLES);

    mul_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc, mcand, mplier, addend;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !flush) state_nxt = BUSY;
            BUSY:    if (flush || cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The load edge does no arithmetic; the last of MUL_CYCLES steps is folded into result.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            cnt    <= CNT_W'(MUL_CYCLES - 1);
        end else if (state == BUSY && cnt != '0) begin
            acc    <= acc + addend;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - 1'b1;
        end
    end

    assign addend = mplier[0] ? mcand : '0;
    assign result = acc + addend;
    assign busy   = (state == BUSY);
    assign last   = busy && (cnt == '0);

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ALU, NZCV flag register, branch resolution and the E/M pipeline register.
// Define EXE_MUL_EN to build the iterative multiplier; without it ALU op MUL is undefined.
module exe_stage
    import exe_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_M,
    input  logic             pcload_E,
    input  logic             regw_E,
    input  logic             memw_E,
    input  logic             regmem_E,
    input  logic             branch_E,
    input  logic             ALUope_E,
    input  logic             flag_E,
    input  logic [3:0]       ALUctrl_E,
    input  logic [3:0]       regScr_E,
    input  logic [WIDTH-1:0] regA_E,
    input  logic [WIDTH-1:0] regB_E,
    input  logic [WIDTH-1:0] inm_E,
    output logic             stall_E,
    output logic             pcsel_E,
    output logic [WIDTH-1:0] target_E,
    output logic [3:0]       flags_o,
    output logic             regw_M,
    output logic             memw_M,
    output logic             regmem_M,
    output logic [3:0]       regScr_M,
    output logic [WIDTH-1:0] aluout_M,
    output logic [WIDTH-1:0] wdata_M
);
    localparam int SH_W = $clog2(WIDTH);

    if (MUL_CYCLES != WIDTH) begin : g_cfg_check
        $error("exe_stage: MUL_CYCLES must equal WIDTH");
    end

    alu_op_t          alu_op;
    flags_t           flags_q, flags_nxt;
    logic [WIDTH-1:0] opb, alu_res, sub_diff;
    logic [WIDTH:0]   add_full;
    logic             carry, ovf, op_def, flag_upd;

    assign alu_op   = alu_op_t'(ALUctrl_E);
    assign opb      = ALUope_E ? inm_E : regB_E;
    assign add_full = {1'b0, regA_E} + {1'b0, opb};
    assign sub_diff = regA_E - opb;

`ifdef EXE_MUL_EN
    logic             is_mul, mul_start, mul_busy, mul_last;
    logic [WIDTH-1:0] mul_result;

    assign is_mul    = (alu_op == OP_MUL);
    assign mul_start = is_mul & ~mul_busy & ~flush_M;
    // Stall from the accept cycle until the last iteration, which retires the result.
    assign stall_E   = (is_mul & ~mul_busy) | (mul_busy & ~mul_last);

    seq_mul #(.WIDTH(WIDTH), .MUL_CYCLES(MUL_CYCLES)) u_seq_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mul_start),
        .a      (regA_E),
        .b      (opb),
        .flush  (flush_M),
        .busy   (mul_busy),
        .last   (mul_last),
        .result (mul_result)
    );
`else
    assign stall_E = 1'b0;
`endif

    always_comb begin
        alu_res = '0;
        carry   = flags_q.c;
        ovf     = flags_q.v;
        op_def  = 1'b1;
        case (alu_op)
            OP_ADD: begin
                alu_res = add_full[WIDTH-1:0];
                carry   = add_full[WIDTH];
                ovf     = (regA_E[WIDTH-1] == opb[WIDTH-1]) & (add_full[WIDTH-1] != regA_E[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                alu_res = sub_diff;
                carry   = (regA_E >= opb);
                ovf     = (regA_E[WIDTH-1] != opb[WIDTH-1]) & (sub_diff[WIDTH-1] != regA_E[WIDTH-1]);
            end
            OP_AND: alu_res = regA_E & opb;
            OP_OR:  alu_res = regA_E | opb;
            OP_XOR: alu_res = regA_E ^ opb;
            OP_SHL: alu_res = regA_E << opb[SH_W-1:0];
            OP_SHR: alu_res = regA_E >> opb[SH_W-1:0];
`ifdef EXE_MUL_EN
            OP_MUL: alu_res = mul_result;
`else
            OP_MUL: op_def = 1'b0;
`endif
            OP_MOV: alu_res = opb;
            default: op_def = 1'b0;
        endcase
        flags_nxt.n = alu_res[WIDTH-1];
        flags_nxt.z = (alu_res == '0);
        flags_nxt.c = carry;
        flags_nxt.v = ovf;
    end

    assign flag_upd = flag_E & op_def;
    assign flags_o  = flags_q;
    assign target_E = alu_res;
    // Branch sees the flags as they stood before this instruction updates them.
    assign pcsel_E  = ~stall_E & (pcload_E | (branch_E & flags_q.z));

    // E/M boundary: flush and stall both insert a bubble and leave the flags untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regw_M   <= BUBBLE_CTL;
            memw_M   <= BUBBLE_CTL;
            regmem_M <= BUBBLE_CTL;
            regScr_M <= BUBBLE_SCR;
            aluout_M <= WIDTH'(BUBBLE_DATA);
            wdata_M  <= WIDTH'(BUBBLE_DATA);
            flags_q  <= '0;
        end else if (flush_M || stall_E) begin
            regw_M   <= BUBBLE_CTL;
            memw_M   <= BUBBLE_CTL;
            regmem_M <= BUBBLE_CTL;
            regScr_M <= BUBBLE_SCR;
            aluout_M <= WIDTH'(BUBBLE_DATA);
            wdata_M  <= WIDTH'(BUBBLE_DATA);
        end else begin
            regw_M   <= regw_E & (alu_op != OP_CMP);
            memw_M   <= memw_E;
            regmem_M <= regmem_E;
            regScr_M <= regScr_E;
            aluout_M <= alu_res;
            wdata_M  <= regB_E;
            if (flag_upd) flags_q <= flags_nxt;
        end
    end

endmodule
